// File: rtl/iob_uart16550_tx_streamer.sv
// iob_uart16550_tx_streamer
//
// IOb master that sets up an iob_uart16550 for transmit-only use. After
// reset it writes the divisor latch, line control and FIFO control registers.
// It then queues stream bytes in a local FIFO and writes them to THR in
// bursts. Each burst is gated by an LSR read that reports THRE=1.
//
// Optional feature macro: UART_STREAMER_CNT_EN adds tx_count_o, a 32-bit
// wrapping count of accepted THR writes. Configuration writes are not counted.
//
// Ports:
//   clk_i, arst_i        clock, asynchronous active-high reset
//   cke_i                clock enable; all state holds while low
//   s_data_i/s_valid_i   input byte stream; s_ready_o = FIFO not full
//   iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o
//                        registered IOb request (wstrb = 0 for reads)
//   iob_ready_i          request accepted when high with avalid
//   iob_rvalid_i, iob_rdata_i
//                        read response
//   init_done_o          configuration sequence complete
//   busy_o               FIFO non-empty or IOb transaction outstanding
//   level_o              FIFO occupancy
//   tx_count_o           (UART_STREAMER_CNT_EN only) accepted THR writes
//
// States:
//   CFG      | five configuration writes, indexed by cfg_idx
//   IDLE     | waiting for the FIFO to hold data
//   LSR_REQ  | LSR read request presented on the bus
//   LSR_WAIT | read accepted; waiting for rvalid, then test THRE
//   TX       | THR writes from the FIFO head, up to TX_BURST of them
module iob_uart16550_tx_streamer #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter logic [15:0] DIV      = 16'd2,
  parameter logic [7:0]  LCR_VAL  = 8'h03,
  parameter int          FIFO_AW  = 4,
  parameter int          TX_BURST = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  cke_i,
  input  logic [7:0]            s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic                  iob_avalid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic                  iob_ready_i,
  input  logic                  iob_rvalid_i,
  input  logic [DATA_W-1:0]     iob_rdata_i,
  output logic                  init_done_o,
  output logic                  busy_o,
  output logic [FIFO_AW:0]      level_o
`ifdef UART_STREAMER_CNT_EN
  ,output logic [31:0]          tx_count_o
`endif
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int SW    = DATA_W / 8;
  localparam int BW    = $clog2(TX_BURST + 1);

  typedef enum logic [2:0] {CFG, IDLE, LSR_REQ, LSR_WAIT, TX} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cfg_idx_q, cfg_idx_d, cfg_sel;
  logic [BW-1:0]       burst_q, burst_d;
  logic                init_done_q, init_done_d;
  logic                avalid_q, avalid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, cfg_addr;
  logic [DATA_W-1:0]   wdata_q, wdata_d, cfg_wdata;
  logic [SW-1:0]       wstrb_q, wstrb_d, cfg_wstrb;

  logic [7:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [FIFO_AW:0]    level_q;
  logic                push, pop, accept;
  logic [7:0]          head, next_head;
  logic                unused_rdata;

  assign unused_rdata = ^{iob_rdata_i[DATA_W-1:14], iob_rdata_i[12:0]};

  assign accept     = avalid_q & iob_ready_i;
  assign s_ready_o  = (level_q != (FIFO_AW+1)'(DEPTH));
  assign push       = cke_i & s_valid_i & s_ready_o;
  assign pop        = cke_i & (state_q == TX) & accept;
  assign rd_ptr_nxt = rd_ptr_q + FIFO_AW'(1);
  assign head       = mem[rd_ptr_q];
  // With one byte left, the only way a burst continues is a same-cycle
  // push; that byte is not in the array yet, so forward it directly.
  assign next_head  = (level_q == (FIFO_AW+1)'(1)) ? s_data_i : mem[rd_ptr_nxt];

  // Index of the configuration write to present next cycle.
  assign cfg_sel = accept ? cfg_idx_q + 3'd1 : cfg_idx_q;

  always_comb begin
    cfg_addr  = '0;
    cfg_wstrb = '0;
    cfg_wdata = '0;
    case (cfg_sel)
      3'd0: begin
        cfg_addr  = ADDR_W'(3);
        cfg_wstrb = SW'(4'b1000);
        cfg_wdata = DATA_W'({LCR_VAL | 8'h80, 24'h0});
      end
      3'd1: begin
        cfg_addr  = ADDR_W'(0);
        cfg_wstrb = SW'(4'b0001);
        cfg_wdata = DATA_W'({24'h0, DIV[7:0]});
      end
      3'd2: begin
        cfg_addr  = ADDR_W'(1);
        cfg_wstrb = SW'(4'b0010);
        cfg_wdata = DATA_W'({16'h0, DIV[15:8], 8'h0});
      end
      3'd3: begin
        cfg_addr  = ADDR_W'(3);
        cfg_wstrb = SW'(4'b1000);
        cfg_wdata = DATA_W'({LCR_VAL, 24'h0});
      end
      3'd4: begin
        cfg_addr  = ADDR_W'(2);
        cfg_wstrb = SW'(4'b0100);
        cfg_wdata = DATA_W'(32'h0007_0000);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cfg_idx_d   = cfg_idx_q;
    burst_d     = burst_q;
    init_done_d = init_done_q;
    avalid_d    = avalid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    unique case (state_q)
      CFG: begin
        if (accept && cfg_idx_q == 3'd4) begin
          state_d     = IDLE;
          avalid_d    = 1'b0;
          init_done_d = 1'b1;
        end else begin
          avalid_d  = 1'b1;
          cfg_idx_d = cfg_sel;
          addr_d    = cfg_addr;
          wdata_d   = cfg_wdata;
          wstrb_d   = cfg_wstrb;
        end
      end
      IDLE: begin
        if (level_q != '0) begin
          state_d  = LSR_REQ;
          avalid_d = 1'b1;
          addr_d   = ADDR_W'(5);
          wdata_d  = '0;
          wstrb_d  = '0;
        end
      end
      LSR_REQ: begin
        if (accept) begin
          state_d  = LSR_WAIT;
          avalid_d = 1'b0;
        end
      end
      LSR_WAIT: begin
        if (iob_rvalid_i) begin
          if (iob_rdata_i[13]) begin
            state_d  = TX;
            burst_d  = BW'(TX_BURST);
            avalid_d = 1'b1;
            addr_d   = ADDR_W'(0);
            wstrb_d  = SW'(1);
            wdata_d  = DATA_W'(head);
          end else begin
            state_d = IDLE;
          end
        end
      end
      TX: begin
        if (accept) begin
          burst_d = burst_q - BW'(1);
          if (burst_q == BW'(1) || (level_q == (FIFO_AW+1)'(1) && !push)) begin
            state_d  = IDLE;
            avalid_d = 1'b0;
          end else begin
            wdata_d = DATA_W'(next_head);
          end
        end
      end
      default: state_d = CFG;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= CFG;
      cfg_idx_q   <= '0;
      burst_q     <= '0;
      init_done_q <= 1'b0;
      avalid_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else if (cke_i) begin
      state_q     <= state_d;
      cfg_idx_q   <= cfg_idx_d;
      burst_q     <= burst_d;
      init_done_q <= init_done_d;
      avalid_q    <= avalid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
    end
  end

  // FIFO storage is not reset; flushing the pointers empties it.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= s_data_i;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   level_q <= level_q + (FIFO_AW+1)'(1);
        2'b01:   level_q <= level_q - (FIFO_AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

`ifdef UART_STREAMER_CNT_EN
  logic [31:0] tx_count_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)   tx_count_q <= '0;
    else if (pop) tx_count_q <= tx_count_q + 32'd1;
  end

  assign tx_count_o = tx_count_q;
`endif

  assign iob_avalid_o = avalid_q;
  assign iob_addr_o   = addr_q;
  assign iob_wdata_o  = wdata_q;
  assign iob_wstrb_o  = wstrb_q;
  assign init_done_o  = init_done_q;
  assign level_o      = level_q;
  assign busy_o       = (level_q != '0) | avalid_q | (state_q == LSR_WAIT);

endmodule

// File: tb/tb_iob_uart16550_tx_streamer.sv
module tb_iob_uart16550_tx_streamer;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b1;
  logic        cke_i = 1'b1;
  logic [7:0]  s_data_i = 8'h00;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic        iob_avalid_o;
  logic [31:0] iob_addr_o;
  logic [31:0] iob_wdata_o;
  logic [3:0]  iob_wstrb_o;
  logic        iob_ready_i = 1'b0;
  logic        iob_rvalid_i = 1'b0;
  logic [31:0] iob_rdata_i = 32'h0;
  logic        init_done_o;
  logic        busy_o;
  logic [4:0]  level_o;
`ifdef UART_STREAMER_CNT_EN
  logic [31:0] tx_count_o;
`endif

  iob_uart16550_tx_streamer dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .cke_i        (cke_i),
    .s_data_i     (s_data_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .iob_avalid_o (iob_avalid_o),
    .iob_addr_o   (iob_addr_o),
    .iob_wdata_o  (iob_wdata_o),
    .iob_wstrb_o  (iob_wstrb_o),
    .iob_ready_i  (iob_ready_i),
    .iob_rvalid_i (iob_rvalid_i),
    .iob_rdata_i  (iob_rdata_i),
    .init_done_o  (init_done_o),
    .busy_o       (busy_o),
    .level_o      (level_o)
`ifdef UART_STREAMER_CNT_EN
    ,.tx_count_o  (tx_count_o)
`endif
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
    int          cyc;
  } txn_t;

  txn_t        log_q[$];
  txn_t        exp_q[$];
  logic [31:0] lsr_q[$];
  logic [7:0]  model_q[$];
  logic        ready_en = 1'b1;
  logic        rd_pend = 1'b0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          exp_tx = 0;

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // UART-side responder: decides ready for the coming edge, logs requests that
  // will be accepted there, and returns LSR data one cycle after a read.
  initial forever begin
    txn_t t;
    @(negedge clk_i);
    iob_rvalid_i = 1'b0;
    if (arst_i) begin
      rd_pend = 1'b0;
    end else if (rd_pend) begin
      iob_rvalid_i = 1'b1;
      iob_rdata_i  = (lsr_q.size() > 0) ? lsr_q.pop_front() : 32'h0000_2000;
      rd_pend      = 1'b0;
    end
    iob_ready_i = ready_en;
    if (!arst_i && iob_avalid_o && iob_ready_i) begin
      t.addr = iob_addr_o;
      t.strb = iob_wstrb_o;
      t.data = iob_wdata_o;
      t.cyc  = cyc;
      log_q.push_back(t);
      if (iob_wstrb_o == 4'b0000) rd_pend = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_txn(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    txn_t t;
    t.addr = a;
    t.strb = s;
    t.data = d;
    t.cyc  = 0;
    exp_q.push_back(t);
  endtask

  task automatic expect_cfg();
    expect_txn(32'd3, 4'b1000, 32'h8300_0000);
    expect_txn(32'd0, 4'b0001, 32'h0000_0002);
    expect_txn(32'd1, 4'b0010, 32'h0000_0000);
    expect_txn(32'd3, 4'b1000, 32'h0300_0000);
    expect_txn(32'd2, 4'b0100, 32'h0007_0000);
  endtask

  task automatic check_log(input string tag);
    int n;
    check({tag, " count"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d] addr", tag, i), log_q[i].addr, exp_q[i].addr);
      check($sformatf("%s[%0d] wstrb", tag, i), {28'h0, log_q[i].strb}, {28'h0, exp_q[i].strb});
      check($sformatf("%s[%0d] wdata", tag, i), log_q[i].data, exp_q[i].data);
    end
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic check_count(input string tag);
`ifdef UART_STREAMER_CNT_EN
    check({tag, " tx_count"}, tx_count_o, exp_tx);
`else
    n_tests = n_tests + 0;
`endif
  endtask

  task automatic wait_init(input string tag, input int max);
    int n = 0;
    while (!init_done_o && n < max) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, " init_done"}, {31'h0, init_done_o}, 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while ((busy_o || level_o != 5'd0) && n < max) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, " busy"}, {31'h0, busy_o}, 32'd0);
    check({tag, " level"}, {27'h0, level_o}, 32'd0);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk_i);
    ready_en = v;
    @(negedge clk_i);
  endtask

  task automatic push_byte(input logic [7:0] b);
    s_data_i  = b;
    s_valid_i = 1'b1;
    @(negedge clk_i);
    s_valid_i = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [3:0] strb, input int max);
    int n = 0;
    while (!(iob_avalid_o && iob_wstrb_o == strb) && n < max) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, " request seen"}, {31'h0, iob_avalid_o}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    arst_i = 1'b1;
    ready_en = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst avalid", {31'h0, iob_avalid_o}, 32'd0);
    check("rst addr", iob_addr_o, 32'd0);
    check("rst wdata", iob_wdata_o, 32'd0);
    check("rst wstrb", {28'h0, iob_wstrb_o}, 32'd0);
    check("rst s_ready", {31'h0, s_ready_o}, 32'd1);
    check("rst init_done", {31'h0, init_done_o}, 32'd0);
    check("rst busy", {31'h0, busy_o}, 32'd0);
    check("rst level", {27'h0, level_o}, 32'd0);
    check_count("rst");

    // Configuration sequence with ready held high
    arst_i = 1'b0;
    log_q.delete();
    wait_init("cfg", 50);
    expect_cfg();
    check_log("cfg");

    // Two bytes, one poll with THRE set, back-to-back THR writes
    lsr_q.push_back(32'h0000_6000);
    s_data_i = 8'h81; s_valid_i = 1'b1;
    @(negedge clk_i);
    s_data_i = 8'h42;
    @(negedge clk_i);
    s_valid_i = 1'b0;
    check("two level", {27'h0, level_o}, 32'd2);
    wait_idle("two", 50);
    if (log_q.size() >= 3)
      check("two consecutive", log_q[2].cyc - log_q[1].cyc, 32'd1);
    else
      check("two log size", log_q.size(), 32'd3);
    expect_txn(32'd5, 4'b0000, 32'h0);
    expect_txn(32'd0, 4'b0001, 32'h81);
    expect_txn(32'd0, 4'b0001, 32'h42);
    check_log("two");
    exp_tx += 2;
    check_count("two");

    // THRE=0 three times, then THRE=1; order preserved
    lsr_q.push_back(32'h0);
    lsr_q.push_back(32'h0);
    lsr_q.push_back(32'h0);
    lsr_q.push_back(32'h0000_2000);
    s_data_i = 8'h11; s_valid_i = 1'b1;
    @(negedge clk_i);
    s_data_i = 8'h22;
    @(negedge clk_i);
    s_valid_i = 1'b0;
    wait_idle("poll", 200);
    repeat (4) expect_txn(32'd5, 4'b0000, 32'h0);
    expect_txn(32'd0, 4'b0001, 32'h11);
    expect_txn(32'd0, 4'b0001, 32'h22);
    check_log("poll");
    exp_tx += 2;
    check_count("poll");

    // Ready low from reset: FIFO fills to 16, then CFG and one full burst
    @(negedge clk_i);
    arst_i = 1'b1;
    ready_en = 1'b0;
    repeat (2) @(negedge clk_i);
    arst_i = 1'b0;
    log_q.delete();
    lsr_q.delete();
    exp_tx = 0;
    model_q.delete();
    for (int i = 0; i < 20; i++) begin
      s_data_i  = 8'hA0 + 8'(i);
      s_valid_i = 1'b1;
      if (s_ready_o) model_q.push_back(s_data_i);
      @(negedge clk_i);
    end
    s_valid_i = 1'b0;
    check("full accepted", model_q.size(), 32'd16);
    check("full s_ready", {31'h0, s_ready_o}, 32'd0);
    check("full level", {27'h0, level_o}, 32'd16);
    check("full init_done", {31'h0, init_done_o}, 32'd0);
    set_ready(1'b1);
    wait_idle("full", 300);
    expect_cfg();
    expect_txn(32'd5, 4'b0000, 32'h0);
    while (model_q.size() > 0) expect_txn(32'd0, 4'b0001, {24'h0, model_q.pop_front()});
    check_log("full");
    exp_tx += 16;
    check_count("full");

    // THR write stalled for 5 cycles
    push_byte(8'h99);
    wait_req("stall rd", 4'b0000, 20);
    set_ready(1'b0);
    wait_req("stall wr", 4'b0001, 20);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall[%0d] avalid", i), {31'h0, iob_avalid_o}, 32'd1);
      check($sformatf("stall[%0d] addr", i), iob_addr_o, 32'd0);
      check($sformatf("stall[%0d] wdata", i), iob_wdata_o, 32'h99);
      check($sformatf("stall[%0d] level", i), {27'h0, level_o}, 32'd1);
      @(negedge clk_i);
    end
    set_ready(1'b1);
    wait_idle("stall", 50);
    expect_txn(32'd5, 4'b0000, 32'h0);
    expect_txn(32'd0, 4'b0001, 32'h99);
    check_log("stall");
    exp_tx += 1;
    check_count("stall");

    // Reset in the middle of a burst with 5 bytes queued
    set_ready(1'b0);
    for (int i = 0; i < 5; i++) push_byte(8'h31 + 8'(i));
    check("mid level", {27'h0, level_o}, 32'd5);
    set_ready(1'b1);
    wait_req("mid wr", 4'b0001, 20);
    #1 arst_i = 1'b1;
    #1;
    check("mid avalid", {31'h0, iob_avalid_o}, 32'd0);
    check("mid level0", {27'h0, level_o}, 32'd0);
    check("mid init_done", {31'h0, init_done_o}, 32'd0);
    check("mid s_ready", {31'h0, s_ready_o}, 32'd1);
    log_q.delete();
    lsr_q.delete();
    exp_tx = 0;
    repeat (2) @(negedge clk_i);
    arst_i = 1'b0;
    wait_init("replay", 50);
    repeat (10) @(negedge clk_i);
    expect_cfg();
    check_log("replay");
    check("replay level", {27'h0, level_o}, 32'd0);
    check("replay busy", {31'h0, busy_o}, 32'd0);
    check_count("replay");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_uart16550_tx_streamer.md
# iob_uart16550_tx_streamer

Upstream IOb-native master that feeds `iob_uart16550`. It programs the UART's divisor, line control and FIFO control registers after reset. It then buffers bytes from a valid/ready byte stream in a local FIFO and writes them to THR in bursts, each burst gated by an LSR THRE poll. It replaces hand-driven bus transactions for transmit-only UART use.

## Interface
- `ADDR_W`, 32, IOb address width
- `DATA_W`, 32, IOb data width (fixed 32; byte lanes per register offset)
- `DIV`, 16'd2, divisor latch value (DLM:DLL)
- `LCR_VAL`, 8'h03, line control value (DLAB cleared); 8N1 default
- `FIFO_AW`, 4, local FIFO address width (depth 2**FIFO_AW)
- `TX_BURST`, 16, max THR writes per THRE=1 poll; must be ≥1 and ≤16

Ports:
- `clk_i`  in  1  clock
- `arst_i`  in  1  asynchronous reset, active-high
- `cke_i`  in  1  clock enable; all state holds when low
- `s_data_i`  in  8  stream byte
- `s_valid_i`  in  1  stream byte valid
- `s_ready_o`  out  1  stream ready (= FIFO not full)
- `iob_avalid_o`  out  1  request valid
- `iob_addr_o`  out  ADDR_W  register byte offset
- `iob_wdata_o`  out  DATA_W  write data, byte in lane offset%4
- `iob_wstrb_o`  out  DATA_W/8  `1<<(offset%4)` for writes, 0 for reads
- `iob_ready_i`  in  1  request accepted when high with avalid
- `iob_rvalid_i`  in  1  read data valid
- `iob_rdata_i`  in  DATA_W  read data
- `init_done_o`  out  1  configuration sequence complete
- `busy_o`  out  1  FIFO non-empty or IOb transaction outstanding
- `level_o`  out  FIFO_AW+1  FIFO occupancy

## Operation
- States: CFG, IDLE, LSR_REQ, LSR_WAIT, TX.
- CFG: five writes in order, `cfg_idx` 0..4:
  - (3, 1000, `{LCR_VAL|8'h80,24'h0}`)
  - (0, 0001, `DIV[7:0]`)
  - (1, 0010, `DIV[15:8]<<8`)
  - (3, 1000, `{LCR_VAL,24'h0}`)
  - (2, 0100, `8'h07<<16`)
- After the 5th accepted write: `init_done_o`=1 and go to IDLE.
- IDLE: if FIFO non-empty, go to LSR_REQ.
- LSR_REQ: read addr 5, wstrb 0. Once accepted, go to LSR_WAIT.
- LSR_WAIT: wait for `iob_rvalid_i`. If `iob_rdata_i[13]` (THRE) is 1, load burst counter with TX_BURST and go to TX; else go to IDLE.
- TX: write addr 0, wstrb 0001, wdata = FIFO head.
  - FIFO pops on each accepted write; counter decrements.
  - Exit to IDLE when counter reaches 0 or FIFO becomes empty.
- The FIFO accepts input in every state, including CFG.
- Push and pop in the same cycle: occupancy unchanged.
- Pushing while full is impossible, because `s_ready_o`=0.

## Timing
- Reset values: `iob_avalid_o`=0, `iob_addr_o`=0, `iob_wdata_o`=0, `iob_wstrb_o`=0, `s_ready_o`=1, `init_done_o`=0, `busy_o`=0, `level_o`=0, state=CFG.
- All IOb outputs are registered.
- Request handshake:
  - `avalid`/`addr`/`wdata`/`wstrb` stay stable from assertion until the cycle `iob_ready_i`=1.
  - A write is complete on acceptance.
  - Back-to-back writes are allowed with no idle cycle.
- Read handshake:
  - `avalid` drops in the cycle after acceptance.
  - rvalid is accepted ≥1 cycle after acceptance.
  - Only one read is outstanding at a time.
- Latencies:
  - First FIFO byte to LSR request: 2 cycles from IDLE.
  - THRE=1 rvalid to first THR avalid: 1 cycle.
  - THRE=0: next LSR request 2 cycles after rvalid.
- Reset mid-operation drops `avalid` immediately, flushes the FIFO and restarts CFG.
- FIFO pointers wrap modulo 2**FIFO_AW. Occupancy is tracked with FIFO_AW+1 bits.

## Configuration
- `UART_STREAMER_CNT_EN` defined:
  - Adds port `tx_count_o` out 32: count of accepted THR writes.
  - Resets to 0 and wraps from 0xFFFFFFFF to 0.
  - Does not count CFG writes.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

## Test plan
- Reset, `iob_ready_i`=1 constant → exactly the five CFG writes: (3,1000,0x83000000), (0,0001,0x00000002), (1,0010,0x00000000), (3,1000,0x03000000), (2,0100,0x00070000). `init_done_o`=1 after the 5th.
- Push 0x81, 0x42; LSR read returns 0x00006000 → writes (0,0001,0x81) then (0,0001,0x42) on consecutive cycles; `level_o` 2→0; `busy_o` then falls.
- LSR returns 0x00000000 three times, then 0x00002000 → three polls with no THR write, then the byte is written; FIFO order is preserved.
- `iob_ready_i`=0 from reset; offer 20 bytes → 16 accepted, `s_ready_o`=0, `level_o`=16. Release ready → CFG, then one TX_BURST of 16 bytes in order.
- During a THR write hold `iob_ready_i`=0 for 5 cycles → outputs stable, no pop, no duplicate. With `UART_STREAMER_CNT_EN`, `tx_count_o` increments once.
- Assert `arst_i` mid-burst with 5 bytes queued → `iob_avalid_o`=0 the same cycle, `level_o`=0, CFG replays after release.
